// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-file arbiter.
// Holds the sequencer state enum, port identifiers and default bus widths.
// Imported by reg_arb and reg_arb_rr.
package reg_arb_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 4;

    // Port identifiers; also the value held in the last-served pointer.
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/reg_arb_rr.sv
// Two-input arbiter for reg_arb: one-hot grant among req[1:0] while en is high.
// Ports: clk, rst (sync, active-high), req (bit0 = A, bit1 = B), en (arbitration
//        window), upd (grant accepted; advance pointer), gnt (one-hot, 0 when !en).
// Optional macro REG_ARB_FIXED_PRIO_EN: A always wins contention, no pointer kept.
module reg_arb_rr
    import reg_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       upd,
    output logic [1:0] gnt
);

`ifdef REG_ARB_FIXED_PRIO_EN

    // No state needed; the clock/reset/update inputs are intentionally idle.
    logic unused_fixed;
    assign unused_fixed = ^{clk, rst, upd};

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0]) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end

`else

    // Port served most recently; starts at B so A wins the first contention.
    logic last;

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= PORT_B;
        end else if (upd) begin
            last <= gnt[1];
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && req[1]) begin
                gnt = (last == PORT_B) ? 2'b01 : 2'b10;
            end else if (req[0]) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end

`endif

endmodule

// File: rtl/reg_arb.sv
// Arbiter/sequencer sharing one 16x32 register file between ports A and B.
// Ports: clk, rst (sync, active-high); per port x in {a,b}: x_req/x_we/x_addr/x_wdata
//        in, x_ready/x_done/x_rdata out; rf_wr/rf_rd/rf_addr/rf_wdata to the register
//        file, rf_rdata/rf_rvalid from it; busy when not IDLE.
// Optional macro REG_ARB_FIXED_PRIO_EN selects fixed A-first priority (see reg_arb_rr).
module reg_arb
    import reg_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ready,
    output logic                  a_done,
    output logic [DATA_WIDTH-1:0] a_rdata,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ready,
    output logic                  b_done,
    output logic [DATA_WIDTH-1:0] b_rdata,

    output logic                  rf_wr,
    output logic                  rf_rd,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    input  logic                  rf_rvalid,

    output logic                  busy
);

    state_t                state;
    state_t                state_nxt;
    logic [1:0]            gnt;
    logic                  arb_en;
    logic                  accept;
    logic                  port_q;
    logic                  we_q;
    logic                  resp;
    logic                  rd_cap;
    logic [DATA_WIDTH-1:0] a_rdata_q;
    logic [DATA_WIDTH-1:0] b_rdata_q;

    // Grants only exist in IDLE and never while reset is held.
    assign arb_en = (state == IDLE) && !rst;

    reg_arb_rr u_rr (
        .clk (clk),
        .rst (rst),
        .req ({b_req, a_req}),
        .en  (arb_en),
        .upd (accept),
        .gnt (gnt)
    );

    assign a_ready = gnt[0];
    assign b_ready = gnt[1];
    assign accept  = gnt[0] | gnt[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address and write data stay put until the next accept, so the register
    // file's combinational read output is stable through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            port_q   <= PORT_A;
            we_q     <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
        end else if (accept) begin
            port_q   <= gnt[1];
            we_q     <= gnt[1] ? b_we    : a_we;
            rf_addr  <= gnt[1] ? b_addr  : a_addr;
            rf_wdata <= gnt[1] ? b_wdata : a_wdata;
        end
    end

    // Strobes are not masked by rst: a write already in ISSUE at the reset
    // edge still commits in the register file.
    assign rf_wr = (state == ISSUE) &&  we_q;
    assign rf_rd = (state == ISSUE) && !we_q;
    assign busy  = (state != IDLE);

    // A reset arriving during RESP suppresses the done pulse and capture.
    assign resp   = (state == RESP) && !rst;
    assign a_done = resp && (port_q == PORT_A);
    assign b_done = resp && (port_q == PORT_B);
    assign rd_cap = resp && !we_q && rf_rvalid;

    // Read data is forwarded in the done cycle and held afterwards; a missing
    // rf_rvalid leaves the held value untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (rd_cap && a_done) a_rdata_q <= rf_rdata;
            if (rd_cap && b_done) b_rdata_q <= rf_rdata;
        end
    end

    assign a_rdata = (rd_cap && a_done) ? rf_rdata : a_rdata_q;
    assign b_rdata = (rd_cap && b_done) ? rf_rdata : b_rdata_q;

endmodule

// File: tb/tb_reg_arb.sv
// Self-checking bench for reg_arb with a behavioural register file and a
// transaction-level reference model (grant order, memory, held read data).
// Honours REG_ARB_FIXED_PRIO_EN to match the arbitration mode of the RTL.
module tb_reg_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [3:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_ready, a_done, b_ready, b_done;
    logic [31:0] a_rdata, b_rdata;
    logic        rf_wr, rf_rd, rf_rvalid, busy;
    logic [3:0]  rf_addr;
    logic [31:0] rf_wdata, rf_rdata;

    always #5 clk = ~clk;

    reg_arb dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_done(b_done), .b_rdata(b_rdata),
        .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata), .rf_rvalid(rf_rvalid), .busy(busy)
    );

    // Register file stand-in: combinational read, write at edge, rvalid = rd delayed.
    logic [31:0] rf_mem [16];
    logic        rvalid_q = 1'b0;
    logic        kill_rv = 1'b0;
    assign rf_rdata  = rf_mem[rf_addr];
    assign rf_rvalid = rvalid_q && !kill_rv;
    always @(posedge clk) begin
        if (rf_wr) rf_mem[rf_addr] <= rf_wdata;
        rvalid_q <= rf_rd;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic we; logic [3:0] addr; logic [31:0] wdata; } tx_t;
    typedef struct { logic we; logic [3:0] addr; logic [31:0] rdata; } exp_t;

    tx_t  qa[$], qb[$];
    int   exp_order[$];
    exp_t exp_a[$], exp_b[$];

    // Reference model state
    logic [31:0] ref_mem [16];
    logic [31:0] mdl_rd [2];
    int          mdl_last = 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Predict the complete service order of the queued batch, assuming both
    // ports hold their requests continuously from the same IDLE cycle.
    task automatic plan();
        int   ia = 0;
        int   ib = 0;
        int   pick;
        tx_t  t;
        exp_t e;
        while (ia < qa.size() || ib < qb.size()) begin
            if (ia < qa.size() && ib < qb.size()) begin
`ifdef REG_ARB_FIXED_PRIO_EN
                pick = 0;
`else
                pick = (mdl_last == 1) ? 0 : 1;
`endif
            end else begin
                pick = (ia < qa.size()) ? 0 : 1;
            end
            if (pick == 0) begin t = qa[ia]; ia++; end
            else           begin t = qb[ib]; ib++; end
            if (t.we) ref_mem[t.addr] = t.wdata;
            else if (!kill_rv) mdl_rd[pick] = ref_mem[t.addr];
            e.we = t.we; e.addr = t.addr; e.rdata = mdl_rd[pick];
            exp_order.push_back(pick);
            if (pick == 0) exp_a.push_back(e); else exp_b.push_back(e);
            mdl_last = pick;
        end
    endtask

    task automatic present();
        a_req = (qa.size() > 0);
        if (qa.size() > 0) begin a_we = qa[0].we; a_addr = qa[0].addr; a_wdata = qa[0].wdata; end
        b_req = (qb.size() > 0);
        if (qb.size() > 0) begin b_we = qb[0].we; b_addr = qb[0].addr; b_wdata = qb[0].wdata; end
    endtask

    task automatic run_batch();
        int budget = 3 * (qa.size() + qb.size()) + 12;
        int n = 0;
        bit acc_a, acc_b;
        plan();
        present();
        while ((qa.size() > 0 || qb.size() > 0) && n < budget) begin
            @(negedge clk);
            acc_a = a_req && a_ready;
            acc_b = b_req && b_ready;
            @(posedge clk); #1;
            if (acc_a) void'(qa.pop_front());
            if (acc_b) void'(qb.pop_front());
            present();
            n++;
        end
        chk(n < budget, "batch_timeout", n, budget);
        qa.delete(); qb.delete();
        present();
        repeat (4) @(posedge clk);
        #1;
        chk(exp_order.size() == 0 && exp_a.size() == 0 && exp_b.size() == 0,
            "all_done_seen", exp_a.size() + exp_b.size(), 0);
        exp_order.delete(); exp_a.delete(); exp_b.delete();
    endtask

    function automatic tx_t mk(input logic we, input logic [3:0] addr, input logic [31:0] d);
        tx_t t;
        t.we = we; t.addr = addr; t.wdata = d;
        return t;
    endfunction

    // Monitor: grant order, strobe timing, done timing and returned data.
    bit         mon_en = 1'b0;
    bit         mon_pend = 1'b0;
    int         acc_cyc = 0;
    int         acc_port = 0;
    logic       acc_we = 1'b0;
    logic [3:0] acc_addr = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            int   p;
            exp_t e;
            if (a_ready || b_ready) begin
                chk(!(a_ready && b_ready), "one_hot_ready", {a_ready, b_ready}, 1);
                p = b_ready ? 1 : 0;
                chk(exp_order.size() > 0 && exp_order[0] == p, "grant_order", p,
                    (exp_order.size() > 0) ? exp_order[0] : 32'hFFFF_FFFF);
                if (exp_order.size() > 0) void'(exp_order.pop_front());
                mon_pend = 1'b1;
                acc_cyc  = cyc;
                acc_port = p;
                acc_we   = p ? b_we : a_we;
                acc_addr = p ? b_addr : a_addr;
            end
            if (mon_pend && cyc == acc_cyc + 1) begin
                chk(rf_wr == acc_we && rf_rd == !acc_we, "issue_strobe", {rf_wr, rf_rd}, {acc_we, !acc_we});
                chk(rf_addr == acc_addr && busy, "issue_addr", rf_addr, acc_addr);
            end
            if (a_done || b_done) begin
                chk(!(a_done && b_done), "one_hot_done", {a_done, b_done}, 1);
                p = b_done ? 1 : 0;
                chk(mon_pend && p == acc_port && cyc == acc_cyc + 2, "done_timing", cyc - acc_cyc, 2);
                if (p == 0 && exp_a.size() > 0) begin
                    e = exp_a.pop_front();
                    chk(a_rdata == e.rdata, "a_rdata", a_rdata, e.rdata);
                    chk(rf_addr == e.addr, "a_addr_held", rf_addr, e.addr);
                end else if (p == 1 && exp_b.size() > 0) begin
                    e = exp_b.pop_front();
                    chk(b_rdata == e.rdata, "b_rdata", b_rdata, e.rdata);
                    chk(rf_addr == e.addr, "b_addr_held", rf_addr, e.addr);
                end else begin
                    chk(1'b0, "unexpected_done", p, 32'hFFFF_FFFF);
                end
                mon_pend = 1'b0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({rf_wr, rf_rd, a_done, b_done, busy, a_ready, b_ready} == 7'd0, {tag, "_ctrl"},
            {rf_wr, rf_rd, a_done, b_done, busy, a_ready, b_ready}, 0);
        chk(rf_addr == 4'd0 && rf_wdata == 32'd0, {tag, "_rf_bus"}, rf_wdata ^ {28'd0, rf_addr}, 0);
        chk(a_rdata == 32'd0 && b_rdata == 32'd0, {tag, "_rdata"}, a_rdata | b_rdata, 0);
    endtask

    initial begin
        int na, nb, k;
        for (int i = 0; i < 16; i++) begin rf_mem[i] = '0; ref_mem[i] = '0; end
        mdl_rd[0] = '0; mdl_rd[1] = '0;
        rst = 1'b1;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Contention right after reset: A read wins, B write next, then A sees it.
        qa.push_back(mk(0, 4'd1, 32'h0));
        qa.push_back(mk(0, 4'd1, 32'h0));
        qb.push_back(mk(1, 4'd1, 32'h1234_5678));
        run_batch();

        // A write then read-back.
        qa.push_back(mk(1, 4'd3, 32'hDEAD_BEEF));
        qa.push_back(mk(0, 4'd3, 32'h0));
        run_batch();

        // Address boundaries from B.
        qb.push_back(mk(1, 4'd15, 32'hFFFF_FFFF));
        qb.push_back(mk(0, 4'd0,  32'h0));
        qb.push_back(mk(0, 4'd15, 32'h0));
        run_batch();

        // Missing rvalid: done still pulses, held read data unchanged.
        kill_rv = 1'b1;
        qa.push_back(mk(0, 4'd15, 32'h0));
        run_batch();
        kill_rv = 1'b0;

        // Random contention batches.
        for (int r = 0; r < 5; r++) begin
            na = $urandom_range(6, 0);
            nb = $urandom_range(6, 0);
            for (int i = 0; i < na; i++) qa.push_back(mk($urandom_range(1, 0), 4'($urandom_range(15, 0)), $urandom));
            for (int i = 0; i < nb; i++) qb.push_back(mk($urandom_range(1, 0), 4'($urandom_range(15, 0)), $urandom));
            run_batch();
        end

        // Reset during RESP of a B read.
        mon_en = 1'b0;
        b_req = 1; b_we = 0; b_addr = 4'd5;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!b_ready && k < 10);
        chk(b_ready, "rst_test_accept", b_ready, 1);
        @(posedge clk); #1;
        b_req = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        a_req = 1; a_we = 0; a_addr = 4'd0;
        @(negedge clk);
        chk(!b_done && !a_ready, "rst_no_done", {b_done, a_ready}, 0);
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk(a_ready, "ready_after_rst", a_ready, 1);
        a_req = 0;
        mdl_rd[0] = '0; mdl_rd[1] = '0; mdl_last = 1;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Pointer back at B after reset: A wins again.
        qa.push_back(mk(1, 4'd7, 32'hA5A5_0007));
        qb.push_back(mk(0, 4'd7, 32'h0));
        run_batch();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
